// File: rtl/tpu_host_link.sv
// Host-side framed-stream transmitter for the TPU pin protocol: load frames, run/start, result capture and drain.
// Optional checksum trailer on the drained results: define TPU_HOST_LINK_CHECKSUM_EN.
module tpu_host_link #(
  parameter int unsigned RESULT_WAIT = 16,
  parameter int unsigned RES_DEPTH   = 4,
  parameter logic [7:0]  CODE_IDLE   = 8'h00,
  parameter logic [7:0]  CODE_W      = 8'h01,
  parameter logic [7:0]  CODE_INP    = 8'h02,
  parameter logic [7:0]  CODE_INS    = 8'h03,
  parameter logic [7:0]  CODE_START  = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic [7:0] tpu_ui_out,
  output logic [7:0] tpu_uio_out,
  input  logic [7:0] tpu_uo_in,
  output logic       busy,
  output logic       err
);

  localparam int unsigned AW     = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [6:0]  DEPTH7 = 7'(RES_DEPTH);
  localparam logic [7:0]  WAIT8  = 8'(RESULT_WAIT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

  state_t     state, next_state;
  logic [1:0] typ;
  logic [5:0] rem;
  logic [6:0] cap;
  logic [7:0] cnt;
  logic [6:0] wr, rd;
  logic [6:0] drain_len;
  logic [7:0] load_code;
  logic [7:0] buffer [RES_DEPTH];
  logic       accept;

`ifdef TPU_HOST_LINK_CHECKSUM_EN
  logic [7:0] sum;
  assign drain_len = cap + 7'd1;
`else
  assign drain_len = cap;
`endif

  assign accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (s_data[7:6] == 2'b11)    next_state = S_START;
          else if (s_data[5:0] != 6'd0) next_state = S_LOAD;
        end
      end
      S_LOAD:    if (accept && rem == 6'd1) next_state = S_IDLE;
      S_START:   next_state = S_WAIT;
      S_WAIT: begin
        if (cnt == 8'd1) begin
`ifdef TPU_HOST_LINK_CHECKSUM_EN
          next_state = (cap != 7'd0) ? S_CAPTURE : S_DRAIN;
`else
          next_state = (cap != 7'd0) ? S_CAPTURE : S_IDLE;
`endif
        end
      end
      S_CAPTURE: if (wr == cap - 7'd1) next_state = S_DRAIN;
      S_DRAIN:   if (m_ready && rd == drain_len - 7'd1) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == S_IDLE) || (state == S_LOAD);
    busy    = (state != S_IDLE);
    m_valid = (state == S_DRAIN);
    m_data  = buffer[rd[AW-1:0]];
`ifdef TPU_HOST_LINK_CHECKSUM_EN
    if (rd == cap) m_data = sum;
`endif
  end

  always_comb begin
    case (typ)
      2'b00:   load_code = CODE_W;
      2'b01:   load_code = CODE_INP;
      2'b10:   load_code = CODE_INS;
      default: load_code = CODE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      typ         <= 2'b00;
      rem         <= 6'd0;
      cap         <= 7'd0;
      cnt         <= 8'd0;
      wr          <= 7'd0;
      rd          <= 7'd0;
      err         <= 1'b0;
      tpu_ui_out  <= 8'h00;
      tpu_uio_out <= CODE_IDLE;
`ifdef TPU_HOST_LINK_CHECKSUM_EN
      sum         <= 8'h00;
`endif
    end else begin
      tpu_uio_out <= CODE_IDLE;
      if (state == S_IDLE && accept) begin
        typ <= s_data[7:6];
        rem <= s_data[5:0];
        cap <= ({1'b0, s_data[5:0]} > DEPTH7) ? DEPTH7 : {1'b0, s_data[5:0]};
        if (s_data[7:6] == 2'b11 && {1'b0, s_data[5:0]} > DEPTH7) err <= 1'b1;
      end
      // Pins are driven from the next state so CODE_START is visible exactly while in START.
      if (next_state == S_START) tpu_uio_out <= CODE_START;
      if (state == S_LOAD && accept) begin
        tpu_ui_out  <= s_data;
        tpu_uio_out <= load_code;
        rem         <= rem - 6'd1;
      end
      if (state == S_START) begin
        cnt <= WAIT8;
        wr  <= 7'd0;
        rd  <= 7'd0;
`ifdef TPU_HOST_LINK_CHECKSUM_EN
        sum <= 8'h00;
`endif
      end
      if (state == S_WAIT) cnt <= cnt - 8'd1;
      if (state == S_CAPTURE) begin
        wr  <= wr + 7'd1;
`ifdef TPU_HOST_LINK_CHECKSUM_EN
        sum <= sum + tpu_uo_in;
`endif
      end
      if (state == S_DRAIN && m_ready) rd <= rd + 7'd1;
    end
  end

  // NOTE: the result buffer has no reset; it is only read in DRAIN after a full capture rewrites it.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) buffer[wr[AW-1:0]] <= tpu_uo_in;
  end

endmodule
